// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request/response handshake bundle for instr_encoder.
//   Request side : in_valid/in_ready plus opcode, register, funct and immediate fields.
//   Response side: out_valid/out_ready plus encoded instruction word and error flag.
// Modports: master = injector view (drives requests, consumes words);
//           slave  = encoder view.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs opcode/funct/register fields and a signed immediate into an
// RV32I instruction word (U/J/I/shift/B/S/R formats). Two-stage valid/ready pipeline,
// full throughput, in order; counts output handshakes.
// Ports:
//   Clock     - rising-edge clock
//   Reset_n   - asynchronous active-low reset
//   bus       - instr_encoder_if.slave (request fields in, encoded word out)
//   enc_count - number of output handshakes, wraps to 0
// Parameters: COUNT_W (enc_count width), NOP_INSTR (word for unsupported opcode).
// Optional feature macro: IMM_RANGE_CHECK_EN -- flags immediates not representable
// in the selected format via out_err. Without it, out_err only marks unsupported opcodes.
module instr_encoder #(
  parameter int unsigned COUNT_W   = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               Clock,
  input  logic               Reset_n,
  instr_encoder_if.slave     bus,
  output logic [COUNT_W-1:0] enc_count
);

  typedef enum logic [2:0] {
    FMT_U, FMT_J, FMT_I, FMT_SH, FMT_B, FMT_S, FMT_R, FMT_BAD
  } fmt_e;

  // Stage 1 state
  logic        s1_valid_q, s1_valid_d;
  fmt_e        s1_fmt_q, s1_fmt_d;
  logic [6:0]  s1_op_q, s1_op_d;
  logic [4:0]  s1_rd_q, s1_rd_d;
  logic [4:0]  s1_rs1_q, s1_rs1_d;
  logic [4:0]  s1_rs2_q, s1_rs2_d;
  logic [2:0]  s1_f3_q, s1_f3_d;
  logic [6:0]  s1_f7_q, s1_f7_d;
  logic [31:0] s1_imm_q, s1_imm_d;
  // Stage 2 state (drives the output port directly)
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_err_q, out_err_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic        s2_adv;
  logic        in_ready;
  fmt_e        in_fmt;
  logic [31:0] enc_instr;
  logic        enc_err;

  // S1 empties into S2 exactly when S2 can take it, so in_ready depends
  // combinationally on out_ready and a full pipe still streams without bubbles.
  assign s2_adv        = !s2_valid_q || bus.out_ready;
  assign in_ready      = !s1_valid_q || s2_adv;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_err   = out_err_q;
  assign enc_count     = cnt_q;

  // Format select from opcode (and funct3 for the shift-immediate variant)
  always_comb begin
    in_fmt = FMT_BAD;
    case (bus.in_opcode)
      7'b0110111, 7'b0010111: in_fmt = FMT_U;
      7'b1101111:             in_fmt = FMT_J;
      7'b1100111, 7'b0000011: in_fmt = FMT_I;
      7'b0010011:             in_fmt = (bus.in_funct3 == 3'b001 || bus.in_funct3 == 3'b101)
                                       ? FMT_SH : FMT_I;
      7'b1100011:             in_fmt = FMT_B;
      7'b0100011:             in_fmt = FMT_S;
      7'b0110011:             in_fmt = FMT_R;
      default:                in_fmt = FMT_BAD;
    endcase
  end

  // Word packing from S1 registers
  always_comb begin
    enc_instr = NOP_INSTR;
    enc_err   = 1'b0;
    case (s1_fmt_q)
      FMT_U:  enc_instr = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
      FMT_J:  enc_instr = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                           s1_rd_q, s1_op_q};
      FMT_I:  enc_instr = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      FMT_SH: enc_instr = {s1_f7_q, s1_imm_q[4:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      FMT_B:  enc_instr = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                           s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
      FMT_S:  enc_instr = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0],
                           s1_op_q};
      FMT_R:  enc_instr = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      default: begin
        enc_instr = NOP_INSTR;
        enc_err   = 1'b1;
      end
    endcase
`ifdef IMM_RANGE_CHECK_EN
    case (s1_fmt_q)
      FMT_U:  if (s1_imm_q[11:0] != '0) enc_err = 1'b1;
      FMT_J:  if (s1_imm_q[0] || s1_imm_q[31:20] != {12{s1_imm_q[20]}}) enc_err = 1'b1;
      FMT_I,
      FMT_S:  if (s1_imm_q[31:11] != '0 && s1_imm_q[31:11] != '1) enc_err = 1'b1;
      FMT_SH: if (s1_imm_q[31:5] != '0) enc_err = 1'b1;
      FMT_B:  if (s1_imm_q[0] || s1_imm_q[31:12] != {20{s1_imm_q[12]}}) enc_err = 1'b1;
      default: ;
    endcase
`endif
  end

  // Next-state for both stages and the counter
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_fmt_d    = s1_fmt_q;
    s1_op_d     = s1_op_q;
    s1_rd_d     = s1_rd_q;
    s1_rs1_d    = s1_rs1_q;
    s1_rs2_d    = s1_rs2_q;
    s1_f3_d     = s1_f3_q;
    s1_f7_d     = s1_f7_q;
    s1_imm_d    = s1_imm_q;
    s2_valid_d  = s2_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    cnt_d       = cnt_q;

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_instr_d = enc_instr;
        out_err_d   = enc_err;
      end
    end
    if (in_ready) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_fmt_d = in_fmt;
        s1_op_d  = bus.in_opcode;
        s1_rd_d  = bus.in_rd;
        s1_rs1_d = bus.in_rs1;
        s1_rs2_d = bus.in_rs2;
        s1_f3_d  = bus.in_funct3;
        s1_f7_d  = bus.in_funct7;
        s1_imm_d = bus.in_imm;
      end
    end
    if (s2_valid_q && bus.out_ready) cnt_d = cnt_q + COUNT_W'(1);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_fmt_q    <= FMT_BAD;
      s1_op_q     <= '0;
      s1_rd_q     <= '0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_f3_q     <= '0;
      s1_f7_q     <= '0;
      s1_imm_q    <= '0;
      s2_valid_q  <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_fmt_q    <= s1_fmt_d;
      s1_op_q     <= s1_op_d;
      s1_rd_q     <= s1_rd_d;
      s1_rs1_q    <= s1_rs1_d;
      s1_rs2_q    <= s1_rs2_d;
      s1_f3_q     <= s1_f3_d;
      s1_f7_q     <= s1_f7_d;
      s1_imm_q    <= s1_imm_d;
      s2_valid_q  <= s2_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
